// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, Shift/Caps tracking, ASCII lookup,
// and a first-word-fall-through character FIFO for the LCD writer.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    code_i,
    input  logic                          code_valid_i,
    output logic [7:0]                    key_data_o,
    output logic                          key_empty_o,
    input  logic                          key_rd_en_i,
    output logic [$clog2(FIFO_DEPTH):0]   key_count_o,
    output logic                          overflow_o,
    output logic                          shift_o,
    output logic                          caps_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} state_e;

    state_e         state_q, state_d;
    logic           shift_l_q, shift_l_d;
    logic           shift_r_q, shift_r_d;
    logic           caps_q, caps_d;
    logic           caps_held_q, caps_held_d;
    logic           wr_q, wr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic           make_plain, brk_plain, make_ext;
    logic           rd_ok, wr_ok, full;
    logic [8:0]     lk;

    // Returns {hit, ascii}; letters are shifted to uppercase when upper=1.
    function automatic logic [8:0] lookup(input logic [7:0] code, input logic upper);
        logic [8:0] r;
        logic [7:0] l;
        r = '0;
        l = '0;
        case (code)
            8'h1C: l = "a";  8'h32: l = "b";  8'h21: l = "c";  8'h23: l = "d";
            8'h24: l = "e";  8'h2B: l = "f";  8'h34: l = "g";  8'h33: l = "h";
            8'h43: l = "i";  8'h3B: l = "j";  8'h42: l = "k";  8'h4B: l = "l";
            8'h3A: l = "m";  8'h31: l = "n";  8'h44: l = "o";  8'h4D: l = "p";
            8'h15: l = "q";  8'h2D: l = "r";  8'h1B: l = "s";  8'h2C: l = "t";
            8'h3C: l = "u";  8'h2A: l = "v";  8'h1D: l = "w";  8'h22: l = "x";
            8'h35: l = "y";  8'h1A: l = "z";
            8'h45: r = {1'b1, "0"};  8'h16: r = {1'b1, "1"};
            8'h1E: r = {1'b1, "2"};  8'h26: r = {1'b1, "3"};
            8'h25: r = {1'b1, "4"};  8'h2E: r = {1'b1, "5"};
            8'h36: r = {1'b1, "6"};  8'h3D: r = {1'b1, "7"};
            8'h3E: r = {1'b1, "8"};  8'h46: r = {1'b1, "9"};
            8'h29: r = {1'b1, 8'h20};
            8'h5A: r = {1'b1, 8'h0D};
            8'h66: r = {1'b1, 8'h08};
            default: ;
        endcase
        if (l != '0) r = {1'b1, upper ? (l - 8'h20) : l};
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        wr_d        = 1'b0;
        wr_data_d   = wr_data_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        make_plain  = 1'b0;
        brk_plain   = 1'b0;
        make_ext    = 1'b0;

        if (code_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (code_i == 8'hF0)      state_d = ST_BRK;
                    else if (code_i == 8'hE0) state_d = ST_EXT;
                    else if (code_i != 8'hAA) make_plain = 1'b1;
                end
                ST_EXT: begin
                    if (code_i == 8'hF0) begin
                        state_d = ST_EXTBRK;
                    end else begin
                        make_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_plain = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (make_plain) begin
            case (code_i)
                8'h12: shift_l_d = 1'b1;
                8'h59: shift_r_d = 1'b1;
                8'h58: begin
                    if (!caps_held_q) caps_d = ~caps_q;
                    caps_held_d = 1'b1;
                end
                default: ;
            endcase
        end
        if (brk_plain) begin
            case (code_i)
                8'h12: shift_l_d   = 1'b0;
                8'h59: shift_r_d   = 1'b0;
                8'h58: caps_held_d = 1'b0;
                default: ;
            endcase
        end

        // Lookup uses modifier state from before this byte.
        lk = lookup(code_i, (shift_l_q | shift_r_q) ^ caps_q);
        if (make_plain && lk[8]) begin
            wr_d      = 1'b1;
            wr_data_d = lk[7:0];
        end
        if (make_ext && code_i == 8'h5A) begin
            wr_d      = 1'b1;
            wr_data_d = 8'h0D;
        end

        full  = (count_q == CW'(FIFO_DEPTH));
        rd_ok = key_rd_en_i && (count_q != '0);
        wr_ok = wr_q && (!full || rd_ok);
        if (wr_q && !wr_ok) overflow_d = 1'b1;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            wr_q        <= 1'b0;
            wr_data_q   <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            wr_q        <= wr_d;
            wr_data_q   <= wr_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_empty_o = (count_q == '0);
    assign key_data_o  = key_empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign key_count_o = count_q;
    assign overflow_o  = overflow_q;
    assign shift_o     = shift_l_q | shift_r_q;
    assign caps_o      = caps_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with hand-computed expected values.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] code_i;
    logic       code_valid_i;
    logic [7:0] key_data_o;
    logic       key_empty_o;
    logic       key_rd_en_i;
    logic [2:0] key_count_o;
    logic       overflow_o;
    logic       shift_o;
    logic       caps_o;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total_cnt = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_i       (code_i),
        .code_valid_i (code_valid_i),
        .key_data_o   (key_data_o),
        .key_empty_o  (key_empty_o),
        .key_rd_en_i  (key_rd_en_i),
        .key_count_o  (key_count_o),
        .overflow_o   (overflow_o),
        .shift_o      (shift_o),
        .caps_o       (caps_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] c);
        code_i       = c;
        code_valid_i = 1'b1;
        tick();
        code_valid_i = 1'b0;
    endtask

    task automatic pop();
        key_rd_en_i = 1'b1;
        tick();
        key_rd_en_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        code_i       = 8'h00;
        code_valid_i = 1'b0;
        key_rd_en_i  = 1'b0;
        #12;
        rst_n = 1'b1;

        check("rst_empty", 16'(key_empty_o), 16'h1);
        check("rst_count", 16'(key_count_o), 16'h0);
        check("rst_data",  16'(key_data_o),  16'h00);
        check("rst_ovf",   16'(overflow_o),  16'h0);
        check("rst_shift", 16'(shift_o),     16'h0);
        check("rst_caps",  16'(caps_o),      16'h0);

        // Plain 'a' with two-cycle latency.
        strobe(8'h1C);
        check("a_latency_empty", 16'(key_empty_o), 16'h1);
        tick();
        check("a_count", 16'(key_count_o), 16'h1);
        check("a_data",  16'(key_data_o),  16'h61);
        pop();
        check("a_pop_empty", 16'(key_empty_o), 16'h1);

        // Shift held around a make/break of 'a'.
        strobe(8'h12);
        check("shift_held", 16'(shift_o), 16'h1);
        strobe(8'h1C);
        strobe(8'hF0);
        strobe(8'h1C);
        strobe(8'hF0);
        strobe(8'h12);
        check("shift_released", 16'(shift_o), 16'h0);
        tick();
        check("shift_count", 16'(key_count_o), 16'h1);
        check("shift_data",  16'(key_data_o),  16'h41);
        pop();

        // Caps Lock with typematic repeats toggles once.
        strobe(8'h58);
        strobe(8'h58);
        strobe(8'h58);
        strobe(8'hF0);
        strobe(8'h58);
        check("caps_once", 16'(caps_o), 16'h1);
        strobe(8'h1C);
        tick();
        check("caps_data", 16'(key_data_o), 16'h41);
        pop();
        strobe(8'h12);
        strobe(8'h1C);
        tick();
        check("caps_xor_shift", 16'(key_data_o), 16'h61);
        pop();
        strobe(8'hF0);
        strobe(8'h12);

        // Extended codes.
        strobe(8'hE0);
        strobe(8'h5A);
        tick();
        check("kp_enter_count", 16'(key_count_o), 16'h1);
        check("kp_enter_data",  16'(key_data_o),  16'h0D);
        pop();
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h5A);
        tick();
        tick();
        check("ext_break_none", 16'(key_count_o), 16'h0);
        strobe(8'hE0);
        strobe(8'h12);
        check("fake_shift", 16'(shift_o), 16'h0);

        // Overflow: five digits into a four-entry FIFO (caps still on).
        strobe(8'h16);
        strobe(8'h1E);
        strobe(8'h26);
        strobe(8'h25);
        strobe(8'h2E);
        tick();
        check("full_count", 16'(key_count_o), 16'h4);
        check("full_head",  16'(key_data_o),  16'h31);
        check("full_ovf",   16'(overflow_o),  16'h1);
        strobe(8'h36);
        key_rd_en_i = 1'b1;
        tick();
        key_rd_en_i = 1'b0;
        check("full_rw_count", 16'(key_count_o), 16'h4);
        check("full_rw_head",  16'(key_data_o),  16'h32);
        check("drain0", 16'(key_data_o), 16'h32);
        pop();
        check("drain1", 16'(key_data_o), 16'h33);
        pop();
        check("drain2", 16'(key_data_o), 16'h34);
        pop();
        check("drain3", 16'(key_data_o), 16'h36);
        pop();
        check("drain_empty", 16'(key_empty_o), 16'h1);

        // Reset mid-prefix.
        strobe(8'hF0);
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        check("mid_rst_ovf",  16'(overflow_o), 16'h0);
        check("mid_rst_caps", 16'(caps_o),     16'h0);
        strobe(8'h1C);
        tick();
        check("mid_rst_count", 16'(key_count_o), 16'h1);
        check("mid_rst_data",  16'(key_data_o),  16'h61);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
